// File: rtl/vn_alloc_ctrl_pkg.sv
// vn_alloc_ctrl_pkg: sizes and FSM state type shared by the VN allocator files.
package vn_alloc_ctrl_pkg;
    localparam int NUM_PES    = 4;
    localparam int LOG2_PES   = 2;
    localparam int CNT_W      = 16;
    localparam int LANE_CNT_W = LOG2_PES + 1;
    localparam int VN_W       = NUM_PES * LOG2_PES;
    localparam logic [LANE_CNT_W-1:0] PES_L = LANE_CNT_W'(NUM_PES);
    typedef enum logic [1:0] {PACK, STAT, STREAM} vn_alloc_state_t;
endpackage

// File: rtl/vn_alloc_ctrl_if.sv
// vn_alloc_ctrl_if: length-queue input and FAN-controller output bundle of the VN allocator.
interface vn_alloc_ctrl_if;
    import vn_alloc_ctrl_pkg::*;
    logic                  i_len_valid;
    logic [LANE_CNT_W-1:0] i_len;
    logic                  i_len_last;
    logic                  o_len_ready;
    logic [CNT_W-1:0]      i_stream_len;
    logic [VN_W-1:0]       o_vn;
    logic [NUM_PES-1:0]    o_lane_mask;
    logic                  o_stationary;
    logic                  o_data_valid;
    logic                  o_busy;
    logic                  o_err;
    modport master (
        output i_len_valid, i_len, i_len_last, i_stream_len,
        input  o_len_ready, o_vn, o_lane_mask, o_stationary, o_data_valid, o_busy, o_err
    );
    modport slave (
        input  i_len_valid, i_len, i_len_last, i_stream_len,
        output o_len_ready, o_vn, o_lane_mask, o_stationary, o_data_valid, o_busy, o_err
    );
endinterface

// File: rtl/vn_alloc_ctrl_lane_fill.sv
// vn_alloc_ctrl_lane_fill: keeps packed lane ids below used and gives padding lanes unique ids.
module vn_alloc_ctrl_lane_fill
    import vn_alloc_ctrl_pkg::*;
(
    input  logic [LANE_CNT_W-1:0] used_i,
    input  logic [LANE_CNT_W-1:0] k_i,
    input  logic [VN_W-1:0]       ids_i,
    output logic [VN_W-1:0]       vn_o,
    output logic [NUM_PES-1:0]    mask_o
);
    for (genvar j = 0; j < NUM_PES; j++) begin : g_lane
        localparam logic [LANE_CNT_W-1:0] J = LANE_CNT_W'(j);
        logic [LOG2_PES-1:0] pad;
        assign pad = LOG2_PES'(k_i + J - used_i);
        assign mask_o[j] = J < used_i;
        assign vn_o[j*LOG2_PES+:LOG2_PES] = mask_o[j] ? ids_i[j*LOG2_PES+:LOG2_PES] : pad;
    end
endmodule

// File: rtl/vn_alloc_ctrl.sv
// vn_alloc_ctrl: packs VN lengths into NUM_PES-wide folds, then issues one stationary and N streaming beats.
// Define VN_ALLOC_PERF_EN to add the o_perf_folds / o_perf_pad_lanes counters.
module vn_alloc_ctrl
    import vn_alloc_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef VN_ALLOC_PERF_EN
    output logic [31:0] o_perf_folds,
    output logic [31:0] o_perf_pad_lanes,
`endif
    vn_alloc_ctrl_if.slave bus
);
    vn_alloc_state_t state_q, state_d;
    logic [LANE_CNT_W-1:0] used_q, used_d, k_q, k_d;
    logic [VN_W-1:0]       ids_q, ids_d, vn_q, vn_fill;
    logic [NUM_PES-1:0]    mask_q, mask_fill;
    logic [CNT_W-1:0]      len_q, cnt_q;
    logic [LANE_CNT_W:0]   sum;
    logic                  err_q, big, ready, acc, close, done;

    // Oversize words are always taken so they can be dropped and flagged.
    assign big   = bus.i_len > PES_L;
    assign sum   = {1'b0, used_q} + {1'b0, bus.i_len};
    assign ready = state_q == PACK && (big || sum <= {1'b0, PES_L});
    assign acc   = bus.i_len_valid && ready;
    assign done  = (state_q == STAT && len_q == '0) ||
                   (state_q == STREAM && cnt_q == len_q - CNT_W'(1));

    vn_alloc_ctrl_lane_fill u_fill (
        .used_i (used_d),
        .k_i    (k_d),
        .ids_i  (ids_d),
        .vn_o   (vn_fill),
        .mask_o (mask_fill)
    );

    always_comb begin
        used_d = used_q;
        k_d    = k_q;
        ids_d  = ids_q;
        close  = 1'b0;
        if (acc && !big && bus.i_len != '0) begin
            used_d = sum[LANE_CNT_W-1:0];
            k_d    = k_q + LANE_CNT_W'(1);
            for (int j = 0; j < NUM_PES; j++)
                if (LANE_CNT_W'(j) >= used_q && LANE_CNT_W'(j) < used_d)
                    ids_d[j*LOG2_PES+:LOG2_PES] = k_q[LOG2_PES-1:0];
        end
        // In PACK a valid word that is not taken cannot fit, so it closes the fold.
        if (state_q == PACK)
            close = acc ? (used_d == PES_L || (bus.i_len_last && used_d != '0)) : bus.i_len_valid;
        if (done) begin
            used_d = '0;
            k_d    = '0;
        end
        state_d = close ? STAT :
                  state_q == STAT ? (len_q != '0 ? STREAM : PACK) :
                  done ? PACK : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PACK;
            used_q  <= '0;
            k_q     <= '0;
            ids_q   <= '0;
            vn_q    <= '0;
            mask_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            k_q     <= k_d;
            ids_q   <= ids_d;
            cnt_q   <= state_q == STREAM ? cnt_q + CNT_W'(1) : '0;
            if (close) begin
                vn_q   <= vn_fill;
                mask_q <= mask_fill;
                len_q  <= bus.i_stream_len;
            end
            if (acc && big)
                err_q <= 1'b1;
        end
    end

    assign bus.o_len_ready  = ready;
    assign bus.o_vn         = vn_q;
    assign bus.o_lane_mask  = mask_q;
    assign bus.o_stationary = state_q == STAT;
    assign bus.o_data_valid = state_q != PACK;
    assign bus.o_busy       = state_q != PACK || used_q != '0;
    assign bus.o_err        = err_q;

`ifdef VN_ALLOC_PERF_EN
    logic [31:0] folds_q, pad_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            folds_q <= '0;
            pad_q   <= '0;
        end else if (state_q == STAT) begin
            folds_q <= folds_q + 32'd1;
            pad_q   <= pad_q + 32'(PES_L - used_q);
        end
    end
    assign o_perf_folds     = folds_q;
    assign o_perf_pad_lanes = pad_q;
`endif
endmodule

// File: tb/tb_vn_alloc_ctrl.sv
// tb_vn_alloc_ctrl: directed table, corner sequences and random batches scored against a fold-level model.
module tb_vn_alloc_ctrl;
    import vn_alloc_ctrl_pkg::*;
    typedef struct packed {
        logic [7:0]  vn;
        logic [3:0]  mask;
        logic [15:0] slen;
    } fold_t;
    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][2:0]  lens;
        logic [15:0]      slen;
        logic [7:0]       vn;
        logic [3:0]       mask;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    errors = 0;
    int    rem = 0;
    fold_t exp_q[$];
    fold_t cur = '0;
    int    m_used = 0;
    int    m_k = 0;
    int    m_lane[4];
    logic  m_err = 1'b0;
    vec_t  vecs[7];
    fold_t f;
    int    nw, l;

    vn_alloc_ctrl_if bus();
`ifdef VN_ALLOC_PERF_EN
    logic [31:0] perf_folds, perf_pad;
`endif
    vn_alloc_ctrl dut (
        .clk              (clk),
        .rst              (rst),
`ifdef VN_ALLOC_PERF_EN
        .o_perf_folds     (perf_folds),
        .o_perf_pad_lanes (perf_pad),
`endif
        .bus              (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int n, int l0, int l1, int l2, int l3, int slen, int vn, int mask);
        vec_t r;
        r.n    = 3'(n);
        r.lens = {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
        r.slen = 16'(slen);
        r.vn   = 8'(vn);
        r.mask = 4'(mask);
        return r;
    endfunction

    task automatic expect_fold(input logic [7:0] vn, input logic [3:0] mask, input logic [15:0] slen);
        fold_t e;
        e.vn = vn;
        e.mask = mask;
        e.slen = slen;
        exp_q.push_back(e);
    endtask

    // Fold-level reference: lanes listed in order, closed on full, last or overflow.
    task automatic model_close();
        logic [7:0] v = '0;
        for (int j = 0; j < 4; j++) begin
            int id = j < m_used ? m_lane[j] : m_k + j - m_used;
            v = v | (8'(id % 4) << (2 * j));
        end
        expect_fold(v, 4'((1 << m_used) - 1), bus.i_stream_len);
        m_used = 0;
        m_k = 0;
    endtask

    task automatic model_word(input int len, input logic lst);
        if (len > 4) begin
            m_err = 1'b1;
            if (lst && m_used > 0) model_close();
            return;
        end
        if (m_used + len > 4) model_close();
        for (int i = 0; i < len; i++) m_lane[m_used + i] = m_k;
        m_used += len;
        if (len > 0) m_k++;
        if (m_used == 4 || (lst && m_used > 0)) model_close();
    endtask

    task automatic send(input logic [2:0] len, input logic lst);
        int t = 0;
        bus.i_len_valid = 1'b1;
        bus.i_len = len;
        bus.i_len_last = lst;
        #1;
        while (!bus.o_len_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("send_timeout", 32'(t < 100), 1);
        @(negedge clk);
        bus.i_len_valid = 1'b0;
        bus.i_len_last = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((bus.o_busy || exp_q.size() != 0 || rem != 0) && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk("idle_timeout", 32'(t < 200), 1);
        chk("fold_missing", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        #1;
        if (rst) begin
            exp_q.delete();
            rem = 0;
        end else if (bus.o_data_valid) begin
            chk("ready_in_beat", bus.o_len_ready, 0);
            chk("busy_in_beat", bus.o_busy, 1);
            if (bus.o_stationary) begin
                chk("stat_in_stream", rem, 0);
                chk("fold_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("stat_vn", bus.o_vn, cur.vn);
                    chk("stat_mask", bus.o_lane_mask, cur.mask);
                    rem = int'(cur.slen);
                end
            end else begin
                chk("stream_extra", 32'(rem > 0), 1);
                chk("stream_vn", bus.o_vn, cur.vn);
                chk("stream_mask", bus.o_lane_mask, cur.mask);
                if (rem > 0) rem--;
            end
        end else if (rem != 0) begin
            chk("stream_short", rem, 0);
            rem = 0;
        end
    end

    initial begin
        vecs[0] = mk(2, 2, 2, 0, 0, 2, 'h50, 'hF);
        vecs[1] = mk(1, 1, 0, 0, 0, 1, 'hE4, 'h1);
        vecs[2] = mk(1, 4, 0, 0, 0, 0, 'h00, 'hF);
        vecs[3] = mk(4, 1, 1, 1, 1, 1, 'hE4, 'hF);
        vecs[4] = mk(2, 3, 1, 0, 0, 2, 'h40, 'hF);
        vecs[5] = mk(2, 1, 2, 0, 0, 3, 'h94, 'h7);
        vecs[6] = mk(3, 0, 2, 0, 0, 1, 'h90, 'h3);
        bus.i_len_valid = 1'b0;
        bus.i_len = '0;
        bus.i_len_last = 1'b0;
        bus.i_stream_len = 16'd2;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vn", bus.o_vn, 0);
        chk("rst_mask", bus.o_lane_mask, 0);
        chk("rst_stat", bus.o_stationary, 0);
        chk("rst_valid", bus.o_data_valid, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_ready", bus.o_len_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            bus.i_stream_len = vecs[v].slen;
            expect_fold(vecs[v].vn, vecs[v].mask, vecs[v].slen);
            for (int i = 0; i < int'(vecs[v].n); i++)
                send(vecs[v].lens[i], i == int'(vecs[v].n) - 1);
            wait_idle();
            chk("vec_ready_idle", bus.o_len_ready, 1);
        end

        // Overflowing word closes fold A and is re-offered to fold B.
        bus.i_stream_len = 16'd2;
        expect_fold(8'h40, 4'h7, 16'd2);
        expect_fold(8'h90, 4'h3, 16'd2);
        send(3'd3, 1'b0);
        send(3'd2, 1'b1);
        wait_idle();

        send(3'd5, 1'b0);
        #1;
        chk("err_set", bus.o_err, 1);
        chk("err_no_lanes", bus.o_busy, 0);
        expect_fold(8'h00, 4'hF, 16'd2);
        send(3'd4, 1'b0);
        wait_idle();
        chk("err_sticky", bus.o_err, 1);

        bus.i_stream_len = 16'd0;
        expect_fold(8'h00, 4'hF, 16'd0);
        send(3'd4, 1'b0);
        #1;
        chk("zero_stream_stat", bus.o_stationary, 1);
        @(negedge clk);
        #1;
        chk("zero_stream_done", bus.o_data_valid, 0);
        chk("zero_stream_ready", bus.o_len_ready, 1);
        wait_idle();

        bus.i_stream_len = 16'd3;
        expect_fold(8'h40, 4'h7, 16'd3);
        send(3'd3, 1'b1);
        @(negedge clk);
        chk("pre_rst_stream", {bus.o_data_valid, bus.o_stationary}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_vn", bus.o_vn, 0);
        chk("mid_rst_mask", bus.o_lane_mask, 0);
        chk("mid_rst_valid", bus.o_data_valid, 0);
        chk("mid_rst_busy", bus.o_busy, 0);
        chk("mid_rst_err", bus.o_err, 0);
        chk("mid_rst_ready", bus.o_len_ready, 1);
        expect_fold(8'hE4, 4'h1, 16'd3);
        send(3'd1, 1'b1);
        wait_idle();

        send(3'd0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("len0_last_busy", bus.o_busy, 0);
        end

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 40; b++) begin
            nw = $urandom_range(1, 6);
            bus.i_stream_len = 16'($urandom_range(0, 3));
            for (int i = 0; i < nw; i++) begin
                l = ($urandom_range(0, 9) == 0) ? 5 + $urandom_range(0, 2) : $urandom_range(0, 4);
                model_word(l, i == nw - 1);
                send(3'(l), i == nw - 1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle();
        end
        chk("rand_err", bus.o_err, m_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
